dmem_wbuf: RTL and testbench
============================

DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 Parameter d_addr_bits, default 6: width of the CPU data address; the MSB selects RAM (0) or MMIO (1).
REQ-002 Parameter fifo_depth, default 4: posted-write FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 d_mem_we  input  1  CPU write strobe.
REQ-006 d_mem_addr  input  d_addr_bits  CPU word address.
REQ-007 d_mem_data  inout  64  CPU data bus; CPU drives it on writes, this block drives it on reads.
REQ-008 p_valid  output  1  peripheral write request.
REQ-009 p_ready  input  1  peripheral accepts the request.
REQ-010 p_addr  output  d_addr_bits-1  peripheral word offset.
REQ-011 p_wdata  output  64  peripheral write data.

Function
REQ-012 RAM region: 2^(d_addr_bits-1) words of 64 bits, indexed by d_mem_addr[d_addr_bits-2:0].
REQ-013 RAM write: on a clock edge with d_mem_we=1 and addr MSB=0, the addressed word takes d_mem_data.
REQ-014 RAM read: with d_mem_we=0 and addr MSB=0, the block drives the addressed word onto d_mem_data combinationally, with zero-cycle latency, as the single-cycle CPU requires.
REQ-015 Bus drive: d_mem_data is driven only when d_mem_we=0 and rst=0; otherwise it is high-Z.
REQ-016 MMIO offset 0 is STATUS.
- Read value: bits[7:0]=count, bit8=empty, bit9=full, bit10=overflow; other bits 0.
REQ-017 An MMIO write to offset 0 does not enter the FIFO; data bit0=1 clears overflow on that edge.
REQ-018 An MMIO write to any nonzero offset pushes {offset, data} into the FIFO at that edge if the FIFO is not full.
REQ-019 An MMIO read of any nonzero offset returns 64'h0.
REQ-020 A push while full, with no pop on the same edge, is dropped and sets the sticky overflow bit.
REQ-021 p_valid equals not-empty; p_addr and p_wdata present the FIFO head.
REQ-022 A pop occurs on an edge where p_valid=1 and p_ready=1.
REQ-023 While p_valid=1 and p_ready=0, p_addr and p_wdata stay stable.
REQ-024 Push and pop on the same edge:
- Both are accepted and count is unchanged.
- This holds when full: the push is accepted, not dropped.
- When empty, no pop occurs, because p_valid=0.
REQ-025 Latency: a push into an empty FIFO at edge N gives p_valid=1 after edge N, in cycle N+1.
REQ-026 Ordering: entries leave strictly in push order.
- Read and write pointers wrap modulo fifo_depth.
- count ranges 0..fifo_depth.
REQ-027 The block never stalls the CPU; RAM accesses are unaffected by FIFO state.

Reset
REQ-028 While rst=1 at an edge:
- count, pointers and overflow clear.
- p_valid=0 in the following cycle.
- Pending entries are discarded, including one mid-handshake.
REQ-029 Pushes and RAM writes presented on a reset edge are ignored.
REQ-030 RAM contents are not reset.
REQ-031 d_mem_data is high-Z while rst=1.

Structure
REQ-032 A shared package holds:
- STATUS_OFFSET=0.
- Status bit positions 8, 9 and 10.
- The overflow-clear bit position 0.
REQ-033 The FIFO is one sub-module, sync_fifo:
- Parameters: width and depth.
- Ports: push, pop, din, dout, count, full, empty.
- dmem_wbuf instantiates it with width d_addr_bits-1+64.

Verification
REQ-034 Write 64'hDEADBEEF_01234567 to addr 5, then read addr 5 -> bus shows 64'hDEADBEEF_01234567; bus is high-Z during the write cycle.
REQ-035 With p_ready=0, write 64'h11 to addr 33 (offset 1) -> next cycle p_valid=1, p_addr=1, p_wdata=64'h11; these hold stable for 5 cycles; p_ready=1 for one cycle -> p_valid=0.
REQ-036 With p_ready=0, write to offsets 1..5 (5 writes, depth 4) -> STATUS reads count=4, full=1, overflow=1; drain delivers offsets 1,2,3,4 in order; write 64'h1 to addr 32 -> overflow=0.
REQ-037 FIFO full, same cycle p_ready=1 and write offset 7 -> count stays 4, overflow stays 0, and offset 7 emerges last.
REQ-038 Two entries queued and p_valid=1 with p_ready=0; assert rst for one cycle -> p_valid=0, STATUS reads 64'h100; RAM addr 5 still holds its prior value.
REQ-039 Push and pop across 10 entries -> pointers wrap and every entry emerges in order.

Source files
------------

// File: rtl/dmem_wbuf_pkg.sv
// Shared constants for the data-memory / posted-write-buffer block.
// Holds the STATUS register layout and the CPU access decode type.
package dmem_wbuf_pkg;

  localparam int STATUS_OFFSET  = 0;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;
  localparam int OVF_CLR_BIT    = 0;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RAM,
    ACC_STATUS,
    ACC_PUSH
  } acc_e;

  function automatic logic [63:0] status_word(input logic [7:0] count,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       ovf);
    logic [63:0] w;
    w                 = '0;
    w[7:0]            = count;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_FULL_BIT]  = full;
    w[STAT_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/dmem_wbuf_if.sv
// Peripheral posted-write bus: valid/ready handshake carrying a word offset and data.
interface dmem_wbuf_if #(
  parameter int d_addr_bits = 6
);
  logic                   p_valid;
  logic                   p_ready;
  logic [d_addr_bits-2:0] p_addr;
  logic [63:0]            p_wdata;

  modport master(output p_valid, output p_addr, output p_wdata, input p_ready);
  modport slave(input p_valid, input p_addr, input p_wdata, output p_ready);
endinterface

// File: rtl/dmem_wbuf_sync_fifo.sv
// Synchronous FIFO with a combinational head; a push is accepted when full only
// if a pop happens on the same edge.
module sync_fifo #(
  parameter int width = 69,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           din,
  output logic [width-1:0]           dout,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int ptr_bits = $clog2(depth);

  logic [width-1:0]    mem [depth];
  logic [ptr_bits-1:0] wr_ptr_reg;
  logic [ptr_bits-1:0] rd_ptr_reg;
  logic [ptr_bits:0]   count_reg;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (ptr_bits + 1)'(depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/dmem_wbuf.sv
// CPU data memory: zero-latency RAM in the low half of the address space and a
// posted-write FIFO towards a peripheral in the high half, with a STATUS word.
module dmem_wbuf
  import dmem_wbuf_pkg::*;
#(
  parameter int d_addr_bits = 6,
  parameter int fifo_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data,
  dmem_wbuf_if.master            pbus
);
  localparam int off_bits  = d_addr_bits - 1;
  localparam int ram_words = 1 << off_bits;
  localparam int cnt_bits  = $clog2(fifo_depth) + 1;

  logic [63:0]          ram [ram_words];
  logic [off_bits-1:0]  off;
  acc_e                 acc;
  logic [63:0]          rd_data;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [cnt_bits-1:0]  fifo_count;
  logic                 overflow_reg;

  assign off = d_mem_addr[off_bits-1:0];

  // Reset masks every access so RAM writes and pushes on a reset edge are ignored.
  always_comb begin
    acc = ACC_IDLE;
    if (!rst) begin
      if (!d_mem_addr[d_addr_bits-1])             acc = ACC_RAM;
      else if (off == off_bits'(STATUS_OFFSET))   acc = ACC_STATUS;
      else                                        acc = ACC_PUSH;
    end
  end

  assign push = d_mem_we && (acc == ACC_PUSH);
  assign pop  = pbus.p_valid && pbus.p_ready;

  always_ff @(posedge clk) begin
    if (d_mem_we && (acc == ACC_RAM)) ram[off] <= d_mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (d_mem_we && (acc == ACC_STATUS) && d_mem_data[OVF_CLR_BIT]) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  sync_fifo #(
    .width(off_bits + 64),
    .depth(fifo_depth)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({off, d_mem_data}),
    .dout ({pbus.p_addr, pbus.p_wdata}),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign pbus.p_valid = !fifo_empty;

  always_comb begin
    rd_data = '0;
    case (acc)
      ACC_RAM:    rd_data = ram[off];
      ACC_STATUS: rd_data = status_word(8'(fifo_count), fifo_empty, fifo_full, overflow_reg);
      default:    rd_data = '0;
    endcase
  end

  assign d_mem_data = (!d_mem_we && !rst) ? rd_data : 64'bz;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: expected reads and peripheral pops are queued at
// issue time and checked by a separate negedge monitor.
module tb_dmem_wbuf;
  localparam int AB = 6;

  logic          clk;
  logic          rst;
  logic          d_mem_we;
  logic [AB-1:0] d_mem_addr;
  wire  [63:0]   d_mem_data;
  logic          cpu_drive;
  logic [63:0]   cpu_wdata;
  logic          rd_pend;

  int checks = 0;
  int errors = 0;

  logic [AB+63-1:0] pq[$];
  logic [63:0]      rd_exp_q[$];
  logic [AB-1:0]    rd_addr_q[$];

  logic             prev_stall = 1'b0;
  logic [AB+63-1:0] prev_head  = '0;

  dmem_wbuf_if #(.d_addr_bits(AB)) pbus();

  dmem_wbuf #(.d_addr_bits(AB), .fifo_depth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_mem_we  (d_mem_we),
    .d_mem_addr(d_mem_addr),
    .d_mem_data(d_mem_data),
    .pbus      (pbus)
  );

  assign d_mem_data = cpu_drive ? cpu_wdata : 64'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: read data, peripheral pops and head stability during back-pressure.
  always @(negedge clk) begin
    logic [63:0]      e;
    logic [AB-1:0]    a;
    logic [AB+63-1:0] pe;
    if (rd_pend) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow got=read exp=none");
      end else begin
        e = rd_exp_q.pop_front();
        a = rd_addr_q.pop_front();
        $display("read  addr=%0d data=%h", a, d_mem_data);
        if (d_mem_data !== e) begin
          errors++;
          $display("FAIL rd addr=%0d got=%h exp=%h", a, d_mem_data, e);
        end
      end
    end
    if (!rst && pbus.p_valid && pbus.p_ready) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pop_underflow got=%h exp=none", {pbus.p_addr, pbus.p_wdata});
      end else begin
        pe = pq.pop_front();
        $display("pop   off=%0d data=%h", pbus.p_addr, pbus.p_wdata);
        if ({pbus.p_addr, pbus.p_wdata} !== pe) begin
          errors++;
          $display("FAIL pop got=%h exp=%h", {pbus.p_addr, pbus.p_wdata}, pe);
        end
      end
    end
    if (prev_stall) begin
      checks++;
      if (!pbus.p_valid || ({pbus.p_addr, pbus.p_wdata} !== prev_head)) begin
        errors++;
        $display("FAIL hold got=%b/%h exp=1/%h", pbus.p_valid, {pbus.p_addr, pbus.p_wdata}, prev_head);
      end
    end
    prev_stall = pbus.p_valid && !pbus.p_ready && !rst;
    prev_head  = {pbus.p_addr, pbus.p_wdata};
  end

  task automatic cpu_write(input logic [AB-1:0] addr, input logic [63:0] data);
    d_mem_we   = 1'b1;
    d_mem_addr = addr;
    cpu_drive  = 1'b1;
    cpu_wdata  = data;
    @(negedge clk);
    $display("write addr=%0d data=%h", addr, data);
    chk("bus_on_write", d_mem_data, data);
    @(posedge clk);
    #1;
    d_mem_we  = 1'b0;
    cpu_drive = 1'b0;
  endtask

  task automatic cpu_read(input logic [AB-1:0] addr, input logic [63:0] exp);
    d_mem_addr = addr;
    rd_exp_q.push_back(exp);
    rd_addr_q.push_back(addr);
    rd_pend = 1'b1;
    @(posedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (pq.size() != 0 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(pq.size()), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    d_mem_we   = 1'b0;
    d_mem_addr = '0;
    cpu_drive  = 1'b0;
    cpu_wdata  = '0;
    rd_pend    = 1'b0;
    pbus.p_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pvalid", 64'(pbus.p_valid), 64'd0);
    rst = 1'b0;
    cpu_read(6'd32, 64'h100);

    // RAM write/read and MMIO read of a nonzero offset
    cpu_write(6'd5, 64'hDEADBEEF_01234567);
    cpu_write(6'd6, 64'h0F0F_0000_1234_5678);
    cpu_write(6'd31, 64'hCAFE_F00D_0000_0031);
    cpu_read(6'd5, 64'hDEADBEEF_01234567);
    cpu_read(6'd6, 64'h0F0F_0000_1234_5678);
    cpu_read(6'd31, 64'hCAFE_F00D_0000_0031);
    cpu_read(6'd63, 64'h0);
    cpu_read(6'd37, 64'h0);

    // Single posted write held under back-pressure
    pbus.p_ready = 1'b0;
    pq.push_back({5'd1, 64'h11});
    cpu_write(6'd33, 64'h11);
    chk("pv_after_push", 64'(pbus.p_valid), 64'd1);
    chk("paddr_after_push", 64'(pbus.p_addr), 64'd1);
    chk("pwdata_after_push", pbus.p_wdata, 64'h11);
    repeat (5) @(posedge clk);
    #1;
    chk("pwdata_held", pbus.p_wdata, 64'h11);
    pbus.p_ready = 1'b1;
    @(posedge clk);
    #1;
    pbus.p_ready = 1'b0;
    chk("pv_after_pop", 64'(pbus.p_valid), 64'd0);

    // Overflow: five writes into a depth-4 FIFO, then clear
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) pq.push_back({5'(i), 64'h100 + 64'(i)});
      cpu_write(6'(32 + i), 64'h100 + 64'(i));
    end
    cpu_read(6'd32, 64'h604);
    cpu_write(6'd32, 64'h1);
    cpu_read(6'd32, 64'h204);

    // Push and pop on the same edge while full
    pbus.p_ready = 1'b1;
    pq.push_back({5'd7, 64'h77});
    cpu_write(6'd39, 64'h77);
    pbus.p_ready = 1'b0;
    cpu_read(6'd32, 64'h204);
    pbus.p_ready = 1'b1;
    wait_drain(20);
    pbus.p_ready = 1'b0;
    chk("pv_drained", 64'(pbus.p_valid), 64'd0);
    cpu_read(6'd32, 64'h100);

    // Reset with entries pending; writes on the reset edge are ignored
    cpu_write(6'd34, 64'hAA);
    cpu_write(6'd35, 64'hBB);
    chk("pv_before_rst", 64'(pbus.p_valid), 64'd1);
    rst        = 1'b1;
    d_mem_we   = 1'b1;
    d_mem_addr = 6'd5;
    cpu_drive  = 1'b1;
    cpu_wdata  = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk);
    #1;
    d_mem_addr = 6'd36;
    cpu_wdata  = 64'hEE;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    d_mem_we  = 1'b0;
    cpu_drive = 1'b0;
    chk("pv_after_rst", 64'(pbus.p_valid), 64'd0);
    cpu_read(6'd32, 64'h100);
    cpu_read(6'd5, 64'hDEADBEEF_01234567);

    // Ten entries through the FIFO with intermittent back-pressure
    for (int i = 0; i < 10; i++) begin
      pbus.p_ready = (i % 3 != 0);
      pq.push_back({5'(i + 1), 64'hA000 + 64'(i)});
      cpu_write(6'(33 + i), 64'hA000 + 64'(i));
    end
    pbus.p_ready = 1'b0;
    cpu_read(6'd32, 64'h204);
    pbus.p_ready = 1'b1;
    wait_drain(20);
    pbus.p_ready = 1'b0;
    cpu_read(6'd32, 64'h100);

    @(posedge clk);
    #1;
    chk("rd_queue_left", 64'(rd_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
